// File: rtl/contador_lote_param.sv
// Batch item counter: counts offered items up to MODULUS, refuses items while full,
// and tallies unloaded batches. Define CONTADOR_LOTE_SAT_EN to saturate the batch total.
module contador_lote_param #(
  parameter int MODULUS     = 12,
  parameter int WIDTH       = 4,
  parameter int BATCH_WIDTH = 8
) (
  input  logic                   Ck,
  input  logic                   clear,
  input  logic                   en,
  input  logic                   unload,
  output logic [WIDTH-1:0]       Q,
  output logic                   S,
  output logic                   ready,
  output logic                   reject,
  output logic [BATCH_WIDTH-1:0] batches
);

  // Handshake: an item transfers on a rising edge when en && ready; en while !ready
  // is refused and flagged on reject for the following cycle.

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} state_e;

  localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);

  logic [WIDTH-1:0]       count_q, count_d;
  logic [BATCH_WIDTH-1:0] batches_q, batches_d;
  logic                   reject_q, reject_d;
  logic [BATCH_WIDTH-1:0] batches_inc;
  state_e                 state;

  // State lives entirely in the count; FULL is decoded, never stored separately.
  assign state = (count_q == MOD_W) ? FULL : FILLING;

  always_ff @(posedge Ck) begin
    if (clear) begin
      count_q   <= '0;
      batches_q <= '0;
      reject_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      batches_q <= batches_d;
      reject_q  <= reject_d;
    end
  end

`ifdef CONTADOR_LOTE_SAT_EN
  assign batches_inc = (batches_q == '1) ? batches_q : batches_q + 1'b1;
`else
  assign batches_inc = batches_q + 1'b1;
`endif

  always_comb begin
    count_d   = count_q;
    batches_d = batches_q;
    reject_d  = 1'b0;
    case (state)
      FILLING: begin
        if (en) count_d = count_q + 1'b1;
      end
      FULL: begin
        if (unload) begin
          // An item offered alongside the unload opens the next batch.
          count_d   = {{(WIDTH-1){1'b0}}, en};
          batches_d = batches_inc;
        end else if (en) begin
          reject_d = 1'b1;
        end
      end
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    Q       = count_q;
    S       = (state == FULL);
    ready   = (state != FULL);
    reject  = reject_q;
    batches = batches_q;
  end

endmodule

// File: tb/tb_contador_lote_param.sv
// Directed bench: default instance (12/4/8) and a small instance (5/3/2) for
// the short-modulus and batch-total overflow cases.
module tb_contador_lote_param;

  logic       Ck;
  logic       a_clear, a_en, a_unload;
  logic [3:0] a_q;
  logic       a_s, a_ready, a_reject;
  logic [7:0] a_batches;

  logic       b_clear, b_en, b_unload;
  logic [2:0] b_q;
  logic       b_s, b_ready, b_reject;
  logic [1:0] b_batches;

  int n_vec  = 0;
  int n_miss = 0;

  contador_lote_param dut_a (
    .Ck(Ck), .clear(a_clear), .en(a_en), .unload(a_unload),
    .Q(a_q), .S(a_s), .ready(a_ready), .reject(a_reject), .batches(a_batches)
  );

  contador_lote_param #(.MODULUS(5), .WIDTH(3), .BATCH_WIDTH(2)) dut_b (
    .Ck(Ck), .clear(b_clear), .en(b_en), .unload(b_unload),
    .Q(b_q), .S(b_s), .ready(b_ready), .reject(b_reject), .batches(b_batches)
  );

  // Clock and reset defaults
  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, then sample 1ns after the next rising edge.
  task automatic a_step(input logic c, input logic e, input logic u);
    a_clear = c; a_en = e; a_unload = u;
    @(posedge Ck); #1;
  endtask

  task automatic b_step(input logic c, input logic e, input logic u);
    b_clear = c; b_en = e; b_unload = u;
    @(posedge Ck); #1;
  endtask

  task automatic a_check_all(input string tag, input int q, input int s,
                             input int rej, input int bat);
    check({tag, ".Q"}, 32'(a_q), 32'(q));
    check({tag, ".S"}, 32'(a_s), 32'(s));
    check({tag, ".ready"}, 32'(a_ready), 32'(s == 0));
    check({tag, ".reject"}, 32'(a_reject), 32'(rej));
    check({tag, ".batches"}, 32'(a_batches), 32'(bat));
  endtask

  initial begin
    int exp_b5;
    int exp_b4;
    a_clear = 1'b1; a_en = 1'b0; a_unload = 1'b0;
    b_clear = 1'b1; b_en = 1'b0; b_unload = 1'b0;
    @(posedge Ck); #1;
    b_clear = 1'b0;
    a_check_all("reset", 0, 0, 0, 0);

    // Fill a batch of 12, checking every increment
    for (int i = 1; i <= 12; i++) begin
      a_step(1'b0, 1'b1, 1'b0);
      check($sformatf("fill%0d.Q", i), 32'(a_q), 32'(i));
      check($sformatf("fill%0d.S", i), 32'(a_s), 32'(i == 12));
    end
    a_check_all("full", 12, 1, 0, 0);

    // Refused items while full: reject continuous, Q held
    for (int i = 0; i < 3; i++) begin
      a_step(1'b0, 1'b1, 1'b0);
      a_check_all($sformatf("refuse%0d", i), 12, 1, 1, 0);
    end
    a_step(1'b0, 1'b0, 1'b0);
    a_check_all("idle_full", 12, 1, 0, 0);

    // Unload and offer in the same cycle: item starts the next batch
    a_step(1'b0, 1'b1, 1'b1);
    a_check_all("unload_en", 1, 0, 0, 1);

    for (int i = 0; i < 6; i++) a_step(1'b0, 1'b1, 1'b0);
    a_check_all("q7", 7, 0, 0, 1);
    a_step(1'b0, 1'b0, 1'b1);
    a_check_all("unload_filling", 7, 0, 0, 1);
    a_step(1'b1, 1'b1, 1'b1);
    a_check_all("clear_mid", 0, 0, 0, 0);

    // Plain unload with no item offered, then clear while full
    for (int i = 0; i < 12; i++) a_step(1'b0, 1'b1, 1'b0);
    a_step(1'b0, 1'b0, 1'b1);
    a_check_all("unload_plain", 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) a_step(1'b0, 1'b1, 1'b0);
    a_step(1'b0, 1'b1, 1'b0);
    a_check_all("refuse_again", 12, 1, 1, 1);
    a_step(1'b1, 1'b1, 1'b1);
    a_check_all("clear_full", 0, 0, 0, 0);
    a_step(1'b0, 1'b0, 1'b0);

    // Small instance: MODULUS=5, BATCH_WIDTH=2
`ifdef CONTADOR_LOTE_SAT_EN
    exp_b4 = 3; exp_b5 = 3;
`else
    exp_b4 = 0; exp_b5 = 1;
`endif
    for (int b = 1; b <= 5; b++) begin
      for (int i = 1; i <= 5; i++) begin
        b_step(1'b0, 1'b1, 1'b0);
        if (b == 1) begin
          check($sformatf("b_fill%0d.Q", i), 32'(b_q), 32'(i));
          check($sformatf("b_fill%0d.S", i), 32'(b_s), 32'(i == 5));
        end
      end
      check($sformatf("b_full%0d.ready", b), 32'(b_ready), 32'd0);
      b_step(1'b0, 1'b0, 1'b1);
      check($sformatf("b_unload%0d.Q", b), 32'(b_q), 32'd0);
      check($sformatf("b_unload%0d.S", b), 32'(b_s), 32'd0);
      if (b == 3) check("b_batches3", 32'(b_batches), 32'd3);
      if (b == 4) check("b_batches4", 32'(b_batches), 32'(exp_b4));
      if (b == 5) check("b_batches5", 32'(b_batches), 32'(exp_b5));
    end
    check("b_reject", 32'(b_reject), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
